// File: rtl/fifo_status_regs_if.sv
// Register bus for the FIFO status window.
//   req_valid/req_write  request strobe and direction (1 = write)
//   req_addr             byte address, only [7:0] decoded by the slave
//   req_wdata/req_wstrb  write data and byte strobes
//   rdata                combinational read data from the slave
interface fifo_status_regs_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic [31:0] rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_wstrb,
    input  rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
    output rdata
  );
endinterface

// File: rtl/fifo_status_regs.sv
// Multi-channel FIFO status/monitor register window.
// Per channel c (base c*0x10): COUNT, STATUS (live empty/full, sticky OVF/UDF/THR W1C),
// HWM (high-water mark, reload-on-write), THRESH (RW). Globals: 0x80 IRQ_EN, 0x84 IRQ_PEND.
//   clk, rst     clock and synchronous active-high reset
//   bus          register bus slave (combinational rdata)
//   fifo_count   channel c count at [c*CNT_W +: CNT_W]
//   fifo_empty   per-channel empty
//   fifo_full    per-channel full
//   fifo_push    per-channel push attempt (before full gating)
//   fifo_pop     per-channel pop attempt (before empty gating)
//   irq          registered level interrupt
module fifo_status_regs #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CNT_W  = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  fifo_status_regs_if.slave       bus,
  input  logic [NUM_CH*CNT_W-1:0] fifo_count,
  input  logic [NUM_CH-1:0]       fifo_empty,
  input  logic [NUM_CH-1:0]       fifo_full,
  input  logic [NUM_CH-1:0]       fifo_push,
  input  logic [NUM_CH-1:0]       fifo_pop,
  output logic                    irq
);

  logic [CNT_W-1:0]  cnt       [NUM_CH];
  logic [CNT_W-1:0]  hwm_q     [NUM_CH];
  logic [CNT_W-1:0]  hwm_d     [NUM_CH];
  logic [CNT_W-1:0]  thresh_q  [NUM_CH];
  logic [CNT_W-1:0]  thresh_d  [NUM_CH];
  logic [NUM_CH-1:0] ovf_q, ovf_d;
  logic [NUM_CH-1:0] udf_q, udf_d;
  logic [NUM_CH-1:0] thr_q, thr_d;
  logic [NUM_CH-1:0] pend;
  logic [2:0]        irq_en_q, irq_en_d;
  logic              irq_q, irq_d;

  // Word-granular decode: [7] global, [6:4] channel, [3:2] register.
  logic       wr_en;
  logic       ch_hit;
  logic [2:0] addr_ch;
  logic [1:0] addr_reg;
  logic       glb_en_hit;
  logic       glb_pend_hit;

  assign wr_en        = bus.req_valid & bus.req_write;
  assign addr_ch      = bus.req_addr[6:4];
  assign addr_reg     = bus.req_addr[3:2];
  assign ch_hit       = ~bus.req_addr[7] & (32'(addr_ch) < NUM_CH);
  assign glb_en_hit   = (bus.req_addr[7:2] == 6'h20);
  assign glb_pend_hit = (bus.req_addr[7:2] == 6'h21);

  logic unused_bits;
  assign unused_bits = ^{bus.req_addr[31:8], bus.req_addr[1:0], bus.req_wdata};

  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt[c] = fifo_count[c*CNT_W +: CNT_W];
    end
  end

  always_comb begin
    logic sel;
    logic w1c;
    irq_en_d = irq_en_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    thr_d    = thr_q;
    pend     = '0;
    sel      = 1'b0;
    w1c      = 1'b0;
    for (int c = 0; c < NUM_CH; c++) begin
      hwm_d[c]    = hwm_q[c];
      thresh_d[c] = thresh_q[c];
    end

    if (wr_en && glb_en_hit && bus.req_wstrb[0]) begin
      irq_en_d = bus.req_wdata[2:0];
    end

    for (int c = 0; c < NUM_CH; c++) begin
      sel = wr_en & ch_hit & (addr_ch == 3'(c));
      w1c = sel & (addr_reg == 2'd1) & bus.req_wstrb[0];

      // Set terms are OR'd after the clear so a same-cycle event wins over W1C.
      ovf_d[c] = (fifo_push[c] & fifo_full[c]) | (ovf_q[c] & ~(w1c & bus.req_wdata[2]));
      udf_d[c] = (fifo_pop[c] & fifo_empty[c]) | (udf_q[c] & ~(w1c & bus.req_wdata[3]));
      thr_d[c] = ((thresh_q[c] != '0) && (cnt[c] >= thresh_q[c]))
               | (thr_q[c] & ~(w1c & bus.req_wdata[4]));

      if (sel && (addr_reg == 2'd2) && (bus.req_wstrb != 4'h0)) begin
        hwm_d[c] = cnt[c];
      end else if (cnt[c] > hwm_q[c]) begin
        hwm_d[c] = cnt[c];
      end

      if (sel && (addr_reg == 2'd3)) begin
        for (int b = 0; b < CNT_W; b++) begin
          if (bus.req_wstrb[b/8]) thresh_d[c][b] = bus.req_wdata[b];
        end
      end

      pend[c] = (ovf_q[c] & irq_en_q[0]) | (udf_q[c] & irq_en_q[1]) | (thr_q[c] & irq_en_q[2]);
    end

    irq_d = |pend;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      irq_en_q <= '0;
      ovf_q    <= '0;
      udf_q    <= '0;
      thr_q    <= '0;
      irq_q    <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        hwm_q[c]    <= '0;
        thresh_q[c] <= '0;
      end
    end else begin
      irq_en_q <= irq_en_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      thr_q    <= thr_d;
      irq_q    <= irq_d;
      for (int c = 0; c < NUM_CH; c++) begin
        hwm_q[c]    <= hwm_d[c];
        thresh_q[c] <= thresh_d[c];
      end
    end
  end

  assign irq = irq_q;

  always_comb begin
    bus.rdata = '0;
    if (ch_hit) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (addr_ch == 3'(c)) begin
          unique case (addr_reg)
            2'd0: bus.rdata[CNT_W-1:0] = cnt[c];
            2'd1: bus.rdata[4:0] = {thr_q[c], udf_q[c], ovf_q[c], fifo_full[c], fifo_empty[c]};
            2'd2: bus.rdata[CNT_W-1:0] = hwm_q[c];
            2'd3: bus.rdata[CNT_W-1:0] = thresh_q[c];
            default: bus.rdata = '0;
          endcase
        end
      end
    end else if (glb_en_hit) begin
      bus.rdata[2:0] = irq_en_q;
    end else if (glb_pend_hit) begin
      bus.rdata[NUM_CH-1:0] = pend;
    end
  end

endmodule

// File: tb/tb_fifo_status_regs.sv
module tb_fifo_status_regs;
  localparam int NUM_CH = 2;
  localparam int CNT_W  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_status_regs_if bus ();
  logic [NUM_CH*CNT_W-1:0] fifo_count;
  logic [NUM_CH-1:0]       fifo_empty, fifo_full, fifo_push, fifo_pop;
  logic                    irq;

  fifo_status_regs #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fifo_count (fifo_count),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full),
    .fifo_push  (fifo_push),
    .fifo_pop   (fifo_pop),
    .irq        (irq)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus counts and reference model state.
  int cnt      [NUM_CH];
  int m_hwm    [NUM_CH];
  int m_thresh [NUM_CH];
  bit m_ovf    [NUM_CH];
  bit m_udf    [NUM_CH];
  bit m_thr    [NUM_CH];
  int m_en;
  bit m_irq;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int m_pend();
    int p = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      if ((m_ovf[c] && m_en[0]) || (m_udf[c] && m_en[1]) || (m_thr[c] && m_en[2]))
        p |= (1 << c);
    end
    return p;
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    int word = int'(a[7:0]) / 4;
    int ch   = word / 4;
    int r    = word % 4;
    if (word == 32) return 32'(m_en);
    if (word == 33) return 32'(m_pend());
    if (word >= 32 || ch >= NUM_CH) return 32'h0;
    case (r)
      0: return 32'(cnt[ch]);
      1: return 32'(int'(fifo_empty[ch]) + 2 * int'(fifo_full[ch]) + 4 * int'(m_ovf[ch])
                   + 8 * int'(m_udf[ch]) + 16 * int'(m_thr[ch]));
      2: return 32'(m_hwm[ch]);
      default: return 32'(m_thresh[ch]);
    endcase
  endfunction

  task automatic pack();
    for (int c = 0; c < NUM_CH; c++) fifo_count[c*CNT_W +: CNT_W] = cnt[c][CNT_W-1:0];
  endtask

  // One clock: drive bus, advance the model by the rules, check irq after the edge.
  task automatic step(input bit wr, input logic [31:0] a, input logic [31:0] wd,
                      input logic [3:0] ws);
    bit new_irq;
    int word = int'(a[7:0]) / 4;
    bus.req_valid = wr;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_wdata = wd;
    bus.req_wstrb = ws;
    pack();
    new_irq = (m_pend() != 0);
    for (int c = 0; c < NUM_CH; c++) begin
      bit hit = wr && (word < 32) && (word / 4 == c);
      bit clr = hit && (word % 4 == 1) && ws[0];
      m_ovf[c] = (fifo_push[c] && fifo_full[c]) || (m_ovf[c] && !(clr && wd[2]));
      m_udf[c] = (fifo_pop[c] && fifo_empty[c]) || (m_udf[c] && !(clr && wd[3]));
      m_thr[c] = (m_thresh[c] != 0 && cnt[c] >= m_thresh[c]) || (m_thr[c] && !(clr && wd[4]));
      if (hit && word % 4 == 2 && ws != 4'h0) m_hwm[c] = cnt[c];
      else if (cnt[c] > m_hwm[c]) m_hwm[c] = cnt[c];
      if (hit && word % 4 == 3) begin
        for (int b = 0; b < 4; b++) begin
          if (ws[b]) m_thresh[c] = (m_thresh[c] & ~(255 << (8 * b))) | (wd & (255 << (8 * b)));
        end
        m_thresh[c] &= (1 << CNT_W) - 1;
      end
    end
    if (wr && word == 32 && ws[0]) m_en = wd & 7;
    m_irq = new_irq;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_ovf[c] = 0; m_udf[c] = 0; m_thr[c] = 0; m_hwm[c] = 0; m_thresh[c] = 0;
      end
      m_en  = 0;
      m_irq = 0;
    end
    @(posedge clk);
    #1;
    chk("irq", {31'b0, irq}, {31'b0, m_irq});
  endtask

  task automatic idle();
    step(1'b0, 32'h0, 32'h0, 4'h0);
  endtask

  task automatic rd(input string tag, input logic [31:0] a);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = a;
    pack();
    #1;
    chk(tag, bus.rdata, m_read(a));
  endtask

  initial begin
    for (int c = 0; c < NUM_CH; c++) begin
      cnt[c] = 0; m_hwm[c] = 0; m_thresh[c] = 0; m_ovf[c] = 0; m_udf[c] = 0; m_thr[c] = 0;
    end
    m_en = 0; m_irq = 0;
    fifo_empty = '1; fifo_full = '0; fifo_push = '0; fifo_pop = '0;
    bus.req_valid = 0; bus.req_write = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_wstrb = 0;
    pack();

    // T1: reset state.
    rst = 1; idle(); idle();
    rst = 0; idle();
    rd("t1_status0", 32'h04);
    chk("t1_status0_lit", bus.rdata, 32'h1);
    rd("t1_irq_en", 32'h80);
    rd("t1_thresh0", 32'h0C);
    rd("t1_hwm0", 32'h08);
    chk("t1_irq_lit", {31'b0, irq}, 32'h0);

    // T2: overflow on ch1, interrupt, W1C.
    fifo_empty = 2'b01; fifo_full = 2'b10; cnt[1] = 255;
    step(1, 32'h80, 32'h1, 4'hF);
    fifo_push = 2'b10; idle(); fifo_push = 2'b00;
    rd("t2_status1", 32'h14);
    chk("t2_ovf_lit", bus.rdata & 32'h4, 32'h4);
    idle();
    chk("t2_irq_lit", {31'b0, irq}, 32'h1);
    rd("t2_pend", 32'h84);
    step(1, 32'h14, 32'h4, 4'hF);
    idle();
    chk("t2_irq_clr_lit", {31'b0, irq}, 32'h0);
    rd("t2_status1_clr", 32'h14);

    // T3: threshold and high-water mark on ch0.
    fifo_full = 2'b00; cnt[1] = 10;
    step(1, 32'h0C, 32'h5, 4'hF);
    for (int v = 0; v <= 7; v++) begin
      cnt[0] = v; fifo_empty[0] = (v == 0); idle();
    end
    for (int v = 6; v >= 2; v--) begin
      cnt[0] = v;
      if (v == 6 || v == 2) step(1, 32'h04, 32'h10, 4'h1);
      else idle();
      if (v == 6) begin
        rd("t3_thr_hold", 32'h04);
        chk("t3_thr_hold_lit", bus.rdata & 32'h10, 32'h10);
      end
    end
    rd("t3_thr_clr", 32'h04);
    chk("t3_thr_clr_lit", bus.rdata & 32'h10, 32'h0);
    rd("t3_hwm", 32'h08);
    chk("t3_hwm_lit", bus.rdata, 32'h7);

    // T4: UDF set beats same-cycle W1C.
    cnt[0] = 0; fifo_empty[0] = 1; fifo_pop = 2'b01;
    step(1, 32'h04, 32'h08, 4'h1);
    fifo_pop = 2'b00;
    rd("t4_udf", 32'h04);
    chk("t4_udf_lit", bus.rdata & 32'h8, 32'h8);

    // T5: HWM reload and unmapped channel.
    cnt[0] = 3; fifo_empty[0] = 0;
    step(1, 32'h08, 32'h0, 4'hF);
    rd("t5_hwm", 32'h08);
    chk("t5_hwm_lit", bus.rdata, 32'h3);
    rd("t5_unmapped", 32'h44);
    chk("t5_unmapped_lit", bus.rdata, 32'h0);

    // T6: reset in the middle of activity.
    fifo_full = 2'b10; fifo_push = 2'b10; idle(); idle();
    chk("t6_irq_pre", {31'b0, irq}, 32'h1);
    rst = 1; step(1, 32'h0C, 32'h9, 4'hF);
    rst = 0; fifo_push = 2'b00; fifo_full = 2'b00;
    chk("t6_irq_lit", {31'b0, irq}, 32'h0);
    rd("t6_status1", 32'h14);
    rd("t6_thresh0", 32'h0C);
    rd("t6_hwm0", 32'h08);
    rd("t6_irq_en", 32'h80);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NUM_CH; c++) cnt[c] = $urandom_range(0, 255);
      fifo_empty = NUM_CH'($urandom());
      fifo_full  = NUM_CH'($urandom());
      fifo_push  = NUM_CH'($urandom());
      fifo_pop   = NUM_CH'($urandom());
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 2) == 0)
        step(1, 32'($urandom_range(0, 35) * 4), $urandom() & 32'h1F1F, 4'($urandom()));
      else
        idle();
      rst = 0;
      rd("rnd_a", 32'($urandom_range(0, 35) * 4));
      rd("rnd_b", 32'($urandom_range(0, 35) * 4));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
